// File: rtl/ochiba_rv32in_nmac.sv
// Ochiba RV32IN packed dot-product/MAC unit: one lane product per cycle, Exnow stalls the front end.
// Build with OCHIBA_NMAC_SAT_EN defined for a 36-bit accumulator with saturating results.
module ochiba_rv32in_nmac #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] acc_in,
    input  logic        flush,
    output logic        Exnow,
    output logic [31:0] result,
    output logic        result_valid
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW    = 2 * LANE_W + 2;
`ifdef OCHIBA_NMAC_SAT_EN
    localparam int ACC_W = 36;
`else
    localparam int ACC_W = 32;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [1:0]         r_op;
    logic [31:0]        r_rs1;
    logic [31:0]        r_rs2;
    logic [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_result;

    logic               w_accept;
    logic               w_done;
    logic [LANE_W-1:0]  w_laneA;
    logic [LANE_W-1:0]  w_laneB;
    logic [PW-1:0]      w_extA;
    logic [PW-1:0]      w_extB;
    logic [PW-1:0]      w_prod;
    logic [ACC_W-1:0]   w_prodExt;
    logic [ACC_W-1:0]   w_seed;
    logic [31:0]        w_final;

    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_done   = (r_state == S_DONE) && !flush;

    assign Exnow        = !flush && (w_accept || (r_state == S_BUSY));
    assign result_valid = w_done;
    // A flushed DONE cycle must not expose the discarded result, so fall back to the held value.
    assign result       = w_done ? w_final : r_result;

    assign w_laneA = r_rs1[int'(r_idx) * LANE_W +: LANE_W];
    assign w_laneB = r_rs2[int'(r_idx) * LANE_W +: LANE_W];

    // Signed ops sign-extend the lanes; the product of the extended values is exact in PW bits.
    assign w_extA = {{(PW - LANE_W){!r_op[0] && w_laneA[LANE_W-1]}}, w_laneA};
    assign w_extB = {{(PW - LANE_W){!r_op[0] && w_laneB[LANE_W-1]}}, w_laneB};
    assign w_prod = w_extA * w_extB;

    generate
        if (ACC_W > PW) begin : g_prodWiden
            assign w_prodExt = {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};
        end else begin : g_prodTrunc
            assign w_prodExt = w_prod[ACC_W-1:0];
        end
    endgenerate

`ifdef OCHIBA_NMAC_SAT_EN
    always_comb begin
        w_seed = '0;
        if (op[1]) begin
            w_seed = op[0] ? {{(ACC_W - 32){1'b0}}, acc_in}
                           : {{(ACC_W - 32){acc_in[31]}}, acc_in};
        end
    end

    // Signed results are in range only when bits [ACC_W-1:31] all agree.
    always_comb begin
        w_final = r_acc[31:0];
        if (r_op[0]) begin
            if (|r_acc[ACC_W-1:32]) begin
                w_final = 32'hFFFF_FFFF;
            end
        end else if (!r_acc[ACC_W-1] && (|r_acc[ACC_W-2:31])) begin
            w_final = 32'h7FFF_FFFF;
        end else if (r_acc[ACC_W-1] && !(&r_acc[ACC_W-2:31])) begin
            w_final = 32'h8000_0000;
        end
    end
`else
    assign w_seed  = op[1] ? acc_in : '0;
    assign w_final = r_acc;
`endif

    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_nextState = S_BUSY;
                S_BUSY: if (r_idx == LAST_IDX) w_nextState = S_DONE;
                S_DONE: w_nextState = S_IDLE;
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_nextState;
            if (flush) begin
                r_acc <= '0;
                r_idx <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_op  <= op;
                            r_rs1 <= rs1;
                            r_rs2 <= rs2;
                            r_acc <= w_seed;
                            r_idx <= '0;
                        end
                    end
                    S_BUSY: begin
                        r_acc <= r_acc + w_prodExt;
                        r_idx <= r_idx + 1'b1;
                    end
                    S_DONE: begin
                        r_result <= w_final;
                    end
                    default: begin
                        r_idx <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ochiba_rv32in_nmac.sv
// Self-checking bench for ochiba_rv32in_nmac: directed cases plus random ops against an arithmetic model.
// Honours OCHIBA_NMAC_SAT_EN so the model saturates exactly when the DUT is built that way.
module tb_ochiba_rv32in_nmac;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] accIn;
    logic        flush;
    logic        Exnow;
    logic [31:0] result;
    logic        result_valid;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] lastResult = 32'd0;

    ochiba_rv32in_nmac #(.LANES(4), .LANE_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .rs1          (rs1),
        .rs2          (rs2),
        .acc_in       (accIn),
        .flush        (flush),
        .Exnow        (Exnow),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Dot product straight from the lane definition, done in 64-bit integers.
    function automatic logic [31:0] modelDot(input logic [1:0] mop, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] acc);
        longint      sum;
        longint      x;
        longint      y;
        logic [7:0]  la;
        logic [7:0]  lb;
        sum = 0;
        if (mop[1]) sum = mop[0] ? longint'({32'd0, acc}) : longint'($signed(acc));
        for (int i = 0; i < 4; i++) begin
            la = a[i*8 +: 8];
            lb = b[i*8 +: 8];
            if (mop[0]) begin
                x = longint'(la);
                y = longint'(lb);
            end else begin
                x = longint'($signed(la));
                y = longint'($signed(lb));
            end
            sum += x * y;
        end
`ifdef OCHIBA_NMAC_SAT_EN
        if (mop[0]) begin
            if (sum > 64'sh0000_0000_FFFF_FFFF) sum = 64'sh0000_0000_FFFF_FFFF;
        end else begin
            if (sum > 64'sd2147483647) sum = 64'sd2147483647;
            else if (sum < -64'sd2147483648) sum = -64'sd2147483648;
        end
`endif
        return sum[31:0];
    endfunction

    // Issues one op, scrambles the operand inputs while it runs, and checks timing and result.
    // start is left high through DONE, as the stalled pipeline would hold it.
    task automatic applyStimulus(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] acc, input string tag);
        logic [31:0] expected;
        int          highCycles;
        int          k;
        bit          seen;
        expected = modelDot(mop, a, b, acc);
        @(negedge clk);
        start = 1'b1;
        flush = 1'b0;
        op    = mop;
        rs1   = a;
        rs2   = b;
        accIn = acc;
        #1;
        checkOutput({tag, "_acceptExnow"}, 32'(Exnow), 32'd1);
        highCycles = 1;
        seen       = 1'b0;
        k          = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            op    = 2'($urandom);
            rs1   = $urandom;
            rs2   = $urandom;
            accIn = $urandom;
            #1;
            if (result_valid) seen = 1'b1;
            else if (Exnow) highCycles++;
        end
        checkOutput({tag, "_latency"}, 32'(k), 32'd5);
        checkOutput({tag, "_exnowCycles"}, 32'(highCycles), 32'd5);
        checkOutput({tag, "_result"}, result, expected);
        checkOutput({tag, "_doneExnow"}, 32'(Exnow), 32'd0);
        lastResult = expected;
    endtask

    task automatic idleCycle(input string tag);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput({tag, "_idleExnow"}, 32'(Exnow), 32'd0);
        checkOutput({tag, "_idleValid"}, 32'(result_valid), 32'd0);
        checkOutput({tag, "_idleHold"}, result, lastResult);
    endtask

    task automatic quietCycles(input string tag, input int n);
        int activity;
        activity = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            #1;
            if (Exnow || result_valid) activity++;
        end
        checkOutput({tag, "_noActivity"}, 32'(activity), 32'd0);
        checkOutput({tag, "_hold"}, result, lastResult);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        rs1   = 32'd0;
        rs2   = 32'd0;
        accIn = 32'd0;
        #2;
        checkOutput("reset_Exnow", 32'(Exnow), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_valid", 32'(result_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        applyStimulus(2'b00, 32'h0102_0304, 32'h0506_0708, $urandom, "dots");
        idleCycle("dots");
        checkOutput("dots_const", result, 32'h0000_0046);

        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h0101_0101, $urandom, "dotsNeg");
        idleCycle("dotsNeg");
        checkOutput("dotsNeg_const", result, 32'hFFFF_FFFC);

        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0101_0101, $urandom, "dotuMax");
        idleCycle("dotuMax");
        checkOutput("dotuMax_const", result, 32'h0000_03FC);

        applyStimulus(2'b10, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_FFFF, "dotsaOvf");
        idleCycle("dotsaOvf");
`ifdef OCHIBA_NMAC_SAT_EN
        checkOutput("dotsaOvf_const", result, 32'h7FFF_FFFF);
`else
        checkOutput("dotsaOvf_const", result, 32'h8000_FC03);
`endif

        // Flush during BUSY discards the op; the following op must start from a fresh accumulator.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        rs1   = 32'hFFFF_FFFF;
        rs2   = 32'hFFFF_FFFF;
        #1;
        checkOutput("flush_acceptExnow", 32'(Exnow), 32'd1);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("flush_exnow", 32'(Exnow), 32'd0);
        checkOutput("flush_valid", 32'(result_valid), 32'd0);
        quietCycles("flush", 8);
        applyStimulus(2'b01, 32'h0000_0002, 32'h0000_0003, $urandom, "afterFlush");
        idleCycle("afterFlush");

        // Asynchronous reset between clock edges while BUSY.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        rs1   = $urandom;
        rs2   = $urandom;
        repeat (2) @(negedge clk);
        #3;
        reset = 1'b1;
        start = 1'b0;
        #1;
        checkOutput("asyncReset_Exnow", 32'(Exnow), 32'd0);
        checkOutput("asyncReset_result", result, 32'd0);
        checkOutput("asyncReset_valid", 32'(result_valid), 32'd0);
        lastResult = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        idleCycle("afterReset");

        // start and flush together in IDLE must not be accepted.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        #1;
        checkOutput("startFlush_exnow", 32'(Exnow), 32'd0);
        quietCycles("startFlush", 7);

        applyStimulus(2'b00, 32'h1122_3344, 32'hF0E0_D0C0, $urandom, "b2bFirst");
        applyStimulus(2'b11, 32'h8081_FF7F, 32'h0203_8001, 32'hFFFF_0000, "b2bSecond");
        idleCycle("b2b");

        for (int n = 0; n < 25; n++) begin
            applyStimulus(2'($urandom), $urandom, $urandom, $urandom, "rand");
            if ($urandom_range(0, 1) == 1) idleCycle("rand");
        end
        idleCycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
